// File: rtl/cve2_rf_writeback_pkg.sv
// Shared writeback types: register-file write request, starvation limit, address legality helper.
// Pure declarations, no timing.
package cve2_rf_writeback_pkg;

  localparam int unsigned WbDataWidth = 32;
  localparam logic [1:0]  StarvLimit  = 2'd2;

  typedef struct packed {
    logic [4:0]             addr;
    logic [WbDataWidth-1:0] data;
  } wb_req_t;

  // x0 is never written; in 16-register mode the upper half of the address space does not exist.
  function automatic logic wb_addr_legal(input logic [4:0] addr, input bit rv32e);
    return (addr != 5'd0) && !(rv32e && addr[4]);
  endfunction

endpackage

// File: rtl/cve2_rf_writeback_fifo.sv
// LSU write buffer: ring of Depth requests with per-entry address match for hazard probing.
// Latency 1 push-to-head; push ignored when full, pop ignored when empty.
module cve2_rf_wb_fifo
  import cve2_rf_writeback_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  wb_req_t          push_req_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output wb_req_t          head_o,
  input  logic [4:0]       chk_addr_i,
  output logic [Depth-1:0] match_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  wb_req_t          mem_q [Depth];
  logic [Depth-1:0] vld_q, vld_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic             push, pop;

  assign full_o  = &vld_q;
  assign empty_o = ~|vld_q;
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Depth is a power of two, so pointer increments wrap on their own.
  always_comb begin
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PtrW'(1);
    end
    if (push) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
  end

  always_comb begin
    match_o = '0;
    for (int i = 0; i < Depth; i++) begin
      match_o[i] = vld_q[i] && (mem_q[i].addr == chk_addr_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_req_i;
    end
  end

endmodule

// File: rtl/cve2_rf_writeback.sv
// Register-file write port arbiter between ALU results and buffered LSU load data.
// Latency 1 grant-to-write; ALU stalls while the LSU buffer drains (bounded by starvation counter), LSU stalls when the buffer is full.
module cve2_rf_writeback
  import cve2_rf_writeback_pkg::*;
#(
  parameter int unsigned DataWidth = WbDataWidth,
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned FifoDepth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 alu_valid_i,
  output logic                 alu_ready_o,
  input  logic [4:0]           alu_waddr_i,
  input  logic [DataWidth-1:0] alu_wdata_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic [4:0]           waddr_a_o,
  output logic [DataWidth-1:0] wdata_a_o,
  output logic                 we_a_o,
  input  logic [4:0]           chk_addr_i,
  output logic                 pend_hit_o,
  output logic                 err_o
);

  wb_req_t              alu_req, lsu_req, head_req, wr_req;
  logic                 fifo_full, fifo_empty;
  logic [FifoDepth-1:0] fifo_match;
  logic                 alu_grant, fifo_pop, lsu_push;
  logic [1:0]           starv_q, starv_d;
  logic                 we_q, we_d;
  logic                 err_q, err_d;
  logic [4:0]           waddr_q, waddr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;

  assign alu_req = '{addr: alu_waddr_i, data: alu_wdata_i};
  assign lsu_req = '{addr: lsu_waddr_i, data: lsu_wdata_i};

  // Load data wins the port unless the ALU has already watched StarvLimit pops go by.
  assign alu_grant = !rst_i && alu_valid_i && (fifo_empty || (starv_q >= StarvLimit));
  assign fifo_pop  = !rst_i && !fifo_empty && !alu_grant;
  assign lsu_push  = !rst_i && lsu_valid_i && !fifo_full;

  assign alu_ready_o = alu_grant;
  assign lsu_ready_o = !rst_i && !fifo_full;

  cve2_rf_wb_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (lsu_push),
    .push_req_i (lsu_req),
    .pop_i      (fifo_pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (head_req),
    .chk_addr_i (chk_addr_i),
    .match_o    (fifo_match)
  );

  always_comb begin
    starv_d = starv_q;
    if (!alu_valid_i || alu_grant) begin
      starv_d = '0;
    end else if (fifo_pop) begin
      starv_d = starv_q + 2'd1;
    end

    wr_req  = alu_grant ? alu_req : head_req;
    we_d    = (alu_grant || fifo_pop) && wb_addr_legal(wr_req.addr, RV32E);
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (alu_grant || fifo_pop) begin
      waddr_d = wr_req.addr;
      wdata_d = wr_req.data;
    end

    // Illegal addresses are flagged when the source hands them over, not when they drain.
    err_d = RV32E && ((alu_grant && alu_waddr_i[4]) || (lsu_push && lsu_waddr_i[4]));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starv_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      starv_q <= starv_d;
      we_q    <= we_d;
      err_q   <= err_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign we_a_o     = we_q;
  assign err_o      = err_q;
  assign waddr_a_o  = waddr_q;
  assign wdata_a_o  = wdata_q;
  assign pend_hit_o = (chk_addr_i != 5'd0) &&
                      ((|fifo_match) || (we_q && (waddr_q == chk_addr_i)));

endmodule
